// File: rtl/uart_rx_main.sv
// uart_rx_main: 16x-oversampling UART receiver.
// Synchronises the serial line, detects the start bit, samples each bit at
// its midpoint and presents the received word with a one-cycle done strobe
// and a framing-error flag. Contains its own free-running baud-tick divisor,
// so a matched TX/RX pair only needs to share clk and parameter values.
module uart_rx_main #(
  parameter int DBIT     = 8,    // data bits per frame, LSB first
  parameter int SB_TICK  = 16,   // oversampling ticks in the stop state (16/24/32)
  parameter int BAUD_DIV = 651   // clk cycles per oversampling tick
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            rx,
  output logic [DBIT-1:0] rx_dout,
  output logic            rx_done_tick,
  output logic            frame_err,
  output logic            busy
);

  // The tick counter must hold BAUD_DIV-1; a divisor of 1 still needs one bit.
  localparam int DIV_W = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;

  // The oversampling counter must reach both 15 (data bits) and SB_TICK-1 (stop).
  localparam int S_MAX = (SB_TICK > 16) ? SB_TICK : 16;
  localparam int S_W   = $clog2(S_MAX);

  // Bit index width; a single-bit frame still needs a one-bit index register.
  localparam int N_W = (DBIT > 1) ? $clog2(DBIT) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(BAUD_DIV - 1);
  localparam logic [S_W-1:0]   S_MID      = S_W'(7);
  localparam logic [S_W-1:0]   S_BIT_END  = S_W'(15);
  localparam logic [S_W-1:0]   S_STOP_END = S_W'(SB_TICK - 1);
  localparam logic [N_W-1:0]   N_LAST     = N_W'(DBIT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    START = 2'b01,
    DATA  = 2'b10,
    STOP  = 2'b11
  } state_t;

  state_t           state;
  logic             rx_meta;
  logic             rx_s;
  logic [DIV_W-1:0] div_cnt;
  logic             s_tick;
  logic [S_W-1:0]   s_reg;
  logic [N_W-1:0]   n_reg;
  logic [DIV_W-1:0] unused_pad;
  logic [DBIT-1:0]  b_reg;

  assign unused_pad = '0;

  // Two-flop synchroniser; both stages reset to the idle (high) line level.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  // Free-running oversampling divisor; never restarted by frame activity.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_cnt <= '0;
    end else if (s_tick) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  assign s_tick = (div_cnt == DIV_LAST);

  // Receive FSM with registered outputs; everything but idle->start waits for a tick.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      s_reg        <= '0;
      n_reg        <= '0;
      b_reg        <= '0;
      rx_dout      <= '0;
      frame_err    <= 1'b0;
      rx_done_tick <= 1'b0;
      busy         <= 1'b0;
    end else begin
      rx_done_tick <= 1'b0;
      case (state)
        IDLE: begin
          if (!rx_s) begin
            s_reg <= '0;
            state <= START;
            busy  <= 1'b1;
          end
        end
        START: begin
          if (s_tick) begin
            if (s_reg == S_MID) begin
              if (!rx_s) begin
                s_reg <= '0;
                n_reg <= '0;
                state <= DATA;
              end else begin
                state <= IDLE;
                busy  <= 1'b0;
              end
            end else begin
              s_reg <= s_reg + 1'b1;
            end
          end
        end
        DATA: begin
          if (s_tick) begin
            if (s_reg == S_BIT_END) begin
              s_reg <= '0;
              b_reg <= {rx_s, b_reg[DBIT-1:1]};
              if (n_reg == N_LAST) begin
                state <= STOP;
              end else begin
                n_reg <= n_reg + 1'b1;
              end
            end else begin
              s_reg <= s_reg + 1'b1;
            end
          end
        end
        STOP: begin
          if (s_tick) begin
            if (s_reg == S_STOP_END) begin
              rx_dout      <= b_reg;
              frame_err    <= ~rx_s;
              rx_done_tick <= 1'b1;
              state        <= IDLE;
              busy         <= 1'b0;
            end else begin
              s_reg <= s_reg + 1'b1;
            end
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_main.sv
// tb_uart_rx_main: directed bench for uart_rx_main at BAUD_DIV=4 (64 clk per bit).
// An ideal transmitter drives rx; a monitor queues every strobe's data, flag
// and the busy level two clocks later, and the main sequence checks them.
module tb_uart_rx_main;

  localparam int DBIT     = 8;
  localparam int SB_TICK  = 16;
  localparam int BAUD_DIV = 4;
  localparam int BIT_CLKS = 16 * BAUD_DIV;

  logic            clk = 1'b0;
  logic            reset_n;
  logic            rx;
  logic [DBIT-1:0] rx_dout;
  logic            rx_done_tick;
  logic            frame_err;
  logic            busy;

  int checks  = 0;
  int passed  = 0;
  int fails   = 0;
  int strobes = 0;

  logic [DBIT-1:0] dout_q[$];
  logic            fe_q[$];
  logic            busy_q[$];
  logic            done_d1 = 1'b0;
  logic            done_d2 = 1'b0;

  uart_rx_main #(
    .DBIT    (DBIT),
    .SB_TICK (SB_TICK),
    .BAUD_DIV(BAUD_DIV)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .rx          (rx),
    .rx_dout     (rx_dout),
    .rx_done_tick(rx_done_tick),
    .frame_err   (frame_err),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  // Capture each strobe's data and flag, and busy two clocks after the strobe.
  always @(negedge clk) begin
    done_d1 <= rx_done_tick;
    done_d2 <= done_d1;
    if (rx_done_tick === 1'b1) begin
      strobes++;
      dout_q.push_back(rx_dout);
      fe_q.push_back(frame_err);
    end
    if (done_d2 === 1'b1) begin
      busy_q.push_back(busy);
    end
  end

  task automatic check_output(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) passed++;
    else begin
      fails++;
      $error("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic idle_line(input int n);
    rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] data, input int bit_clks,
                            input logic stop_val, input int stop_clks);
    rx = 1'b0;
    repeat (bit_clks) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = data[i];
      repeat (bit_clks) @(negedge clk);
    end
    rx = stop_val;
    repeat (stop_clks) @(negedge clk);
    rx = 1'b1;
  endtask

  task automatic expect_frame(input string tag, input logic [7:0] exp_data,
                              input logic exp_fe, input logic chk_busy);
    logic b;
    if (dout_q.size() == 0 || busy_q.size() == 0) begin
      checks++;
      fails++;
      $error("[TB] FAIL %s_strobe: got no rx_done_tick, expected one", tag);
    end else begin
      check_output({tag, "_dout"}, 32'(dout_q.pop_front()), 32'(exp_data));
      check_output({tag, "_ferr"}, 32'(fe_q.pop_front()), 32'(exp_fe));
      b = busy_q.pop_front();
      if (chk_busy) check_output({tag, "_busy"}, 32'(b), 32'd0);
    end
  endtask

  initial begin
    rx      = 1'b1;
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    $display("[TB] reset values");
    check_output("rst_dout", 32'(rx_dout), 32'h0);
    check_output("rst_done", 32'(rx_done_tick), 32'h0);
    check_output("rst_ferr", 32'(frame_err), 32'h0);
    check_output("rst_busy", 32'(busy), 32'h0);
    reset_n = 1'b1;
    idle_line(10);

    $display("[TB] single frame 0x55");
    send_frame(8'h55, BIT_CLKS, 1'b1, BIT_CLKS);
    idle_line(20);
    check_output("f55_count", 32'(strobes), 32'd1);
    expect_frame("f55", 8'h55, 1'b0, 1'b1);

    $display("[TB] back-to-back 0x00 0xFF 0xA5");
    send_frame(8'h00, BIT_CLKS, 1'b1, BIT_CLKS);
    send_frame(8'hFF, BIT_CLKS, 1'b1, BIT_CLKS);
    send_frame(8'hA5, BIT_CLKS, 1'b1, BIT_CLKS);
    idle_line(20);
    check_output("b2b_count", 32'(strobes), 32'd4);
    expect_frame("b2b_00", 8'h00, 1'b0, 1'b1);
    expect_frame("b2b_ff", 8'hFF, 1'b0, 1'b1);
    expect_frame("b2b_a5", 8'hA5, 1'b0, 1'b1);

    // The low stop is held past the stop sample but released before a
    // restarted start check could validate, so only the false start follows.
    $display("[TB] framing error 0x3C then 0x81");
    send_frame(8'h3C, BIT_CLKS, 1'b0, 48);
    idle_line(80);
    send_frame(8'h81, BIT_CLKS, 1'b1, BIT_CLKS);
    idle_line(20);
    check_output("ferr_count", 32'(strobes), 32'd6);
    expect_frame("ferr_3c", 8'h3C, 1'b1, 1'b0);
    expect_frame("ok_81", 8'h81, 1'b0, 1'b1);

    $display("[TB] 20-clk glitch");
    rx = 1'b0;
    repeat (20) @(negedge clk);
    idle_line(100);
    check_output("glitch_count", 32'(strobes), 32'd6);
    check_output("glitch_dout", 32'(rx_dout), 32'h81);
    check_output("glitch_busy", 32'(busy), 32'h0);

    $display("[TB] reset during data bit 4 of 0xC3");
    fork
      send_frame(8'hC3, BIT_CLKS, 1'b1, BIT_CLKS);
      begin
        repeat (5 * BIT_CLKS + 20) @(negedge clk);
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        check_output("mid_rst_dout", 32'(rx_dout), 32'h0);
        check_output("mid_rst_done", 32'(rx_done_tick), 32'h0);
        check_output("mid_rst_ferr", 32'(frame_err), 32'h0);
        check_output("mid_rst_busy", 32'(busy), 32'h0);
      end
    join
    idle_line(10);
    reset_n = 1'b1;
    idle_line(20);
    check_output("mid_rst_count", 32'(strobes), 32'd6);
    send_frame(8'h7E, BIT_CLKS, 1'b1, BIT_CLKS);
    idle_line(20);
    check_output("f7e_count", 32'(strobes), 32'd7);
    expect_frame("f7e", 8'h7E, 1'b0, 1'b1);

    $display("[TB] baud skew 0x96 fast and slow");
    send_frame(8'h96, 62, 1'b1, 62);
    idle_line(20);
    send_frame(8'h96, 66, 1'b1, 66);
    idle_line(20);
    check_output("skew_count", 32'(strobes), 32'd9);
    expect_frame("skew_fast", 8'h96, 1'b0, 1'b1);
    expect_frame("skew_slow", 8'h96, 1'b0, 1'b1);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/uart_rx_main.md
# uart_rx_main

16x-oversampling UART receiver, the receive-side counterpart of the team's UART transmitter. It synchronises the asynchronous serial line `rx` and samples each bit at its midpoint. It then presents each received word as a parallel value with a one-cycle completion strobe and a framing-error flag. The block contains its own baud-tick divisor, so a matched TX/RX pair shares only `clk` and parameter values.

## Interface
Parameters:
- `DBIT`, 8: data bits per frame, LSB first.
- `SB_TICK`, 16: oversampling ticks spent in the stop state. 16, 24 and 32 give 1, 1.5 and 2 stop bits.
- `BAUD_DIV`, 651: `clk` cycles per oversampling tick. Baud rate = f_clk / (16 * `BAUD_DIV`).

Ports:
- `clk`, input, 1: system clock.
- `reset_n`, input, 1: reset, asynchronous, active-low; clock `clk`.
- `rx`, input, 1: asynchronous serial line, idle high.
- `rx_dout`, output, `DBIT`: last received word; holds until the next frame completes.
- `rx_done_tick`, output, 1: one-`clk` pulse when `rx_dout` is updated.
- `frame_err`, output, 1: stop bit of the last frame sampled low; updated together with `rx_done_tick`.
- `busy`, output, 1: high whenever the FSM is not in idle.

## Operation
- Synchroniser: two flops, both reset to 1. All FSM decisions use the second-stage output `rx_s`.
- Tick generator: free-running counter, 0 to `BAUD_DIV`-1, width `$clog2(BAUD_DIV)`. `s_tick` is high for one `clk` when the counter equals `BAUD_DIV`-1; the counter wraps to 0 on the same edge. The counter runs from reset and is never restarted by frame activity.
- Registers:
  - `s_reg`: tick counter, wide enough to hold `SB_TICK`-1 and 15.
  - `n_reg`: bit index, width `$clog2(DBIT)`.
  - `b_reg`: shift register, `DBIT` wide.
- FSM states are idle, start, data and stop. State and counters advance only on `s_tick`, except the idle→start transition.
  - idle: when `rx_s`==0, clear `s_reg` to 0 and go to start. This transition is evaluated every `clk`, not only on ticks.
  - start: on a tick with `s_reg`==7 (mid start bit):
    - if `rx_s`==0: clear `s_reg` and `n_reg`, go to data;
    - else: false start, return to idle with no strobe.
    - On other ticks: increment `s_reg`.
  - data: on a tick with `s_reg`==15:
    - clear `s_reg`;
    - shift in: `b_reg` = {`rx_s`, `b_reg`[DBIT-1:1]};
    - if `n_reg`==`DBIT`-1, go to stop; otherwise increment `n_reg`.
    - On other ticks: increment `s_reg`.
  - stop: on a tick with `s_reg`==`SB_TICK`-1:
    - `rx_dout` <= `b_reg`;
    - `frame_err` <= ~`rx_s`;
    - `rx_done_tick` <= 1;
    - go to idle.
    - On other ticks: increment `s_reg`.
  - Illegal state encodings: go to idle.
- Frames with a framing error still deliver data. `rx_dout` holds the sampled bits and `frame_err`=1.
- Break (`rx` held low): the frame completes with `rx_dout`=0 and `frame_err`=1. The FSM then re-enters start on the next `clk` and repeats while the line stays low.
- There is no overrun detection. A consumer must capture `rx_dout` before the next `rx_done_tick`.

## Timing
- Reset values:
  - `rx_dout`=0, `rx_done_tick`=0, `frame_err`=0, `busy`=0;
  - state idle;
  - `s_reg`, `n_reg`, `b_reg` and the tick counter all 0;
  - synchroniser flops 1.
- Reset asserted mid-frame: the frame is abandoned and no strobe is issued. After release, reception restarts from idle on the next falling edge of `rx_s`.
- All outputs are registered. `rx_done_tick` is high for exactly one `clk` and coincides with the first cycle in which the new `rx_dout` and `frame_err` are visible.
- Synchroniser latency: 2 `clk` from `rx` to `rx_s`.
- Sample points after start detection:
  - start validated at tick 8;
  - data bit k sampled at tick 8+16(k+1), k = 0 to `DBIT`-1;
  - stop sampled at tick 8+16·`DBIT`+`SB_TICK`.
  - With `SB_TICK`=16, the stop sample falls mid-stop-bit.
- Start-detect phase uncertainty: up to 1 tick, because the tick counter is free-running. This is within tolerance for 16x oversampling.
- The FSM returns to idle mid-stop-bit. Back-to-back frames with no idle gap are received without loss.

## Test plan
- Use `BAUD_DIV`=4 in simulation (1 bit = 64 `clk`); the bench drives `rx` with an ideal transmitter model.
- 0x55, valid stop bit → one `rx_done_tick`, `rx_dout`=0x55, `frame_err`=0, `busy` low within 2 `clk` after the strobe.
- Frames 0x00, 0xFF, 0xA5 sent back-to-back with no idle gap → three strobes, in order, values exact, `frame_err`=0 each.
- Frame 0x3C with the stop bit driven low → `rx_dout`=0x3C, `frame_err`=1. A following 0x81 with a valid stop → `frame_err` returns to 0.
- 20-`clk` low glitch on `rx` (shorter than half a bit) → FSM returns to idle, no strobe, `rx_dout` unchanged.
- `reset_n` pulsed low during data bit 4 of 0xC3 → no strobe for that frame, all outputs at reset values. A fresh 0x7E after release → `rx_dout`=0x7E.
- Baud skew: the bench drives bits 3% fast and 3% slow, 0x96 each → both received correctly with `frame_err`=0.
